// File: rtl/peak_sweep_scheduler.sv
// Panel sweep scheduler: settles, samples and averages light at each position,
// parks on the brightest one and hands the peak to a BCD converter.
module peak_sweep_scheduler #(
    parameter int NUM_POS       = 8,
    parameter int POS_W         = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Start,
    input  logic             i_Abort,
    input  logic [11:0]      i_ADC_Value,
    input  logic             i_BCD_Busy,
    output logic [POS_W-1:0] o_Position,
    output logic [11:0]      o_Peak_Value,
    output logic [POS_W-1:0] o_Peak_Position,
    output logic             o_BCD_Start,
    output logic [11:0]      o_BCD_Data,
    output logic             o_Busy,
    output logic             o_Done
);

    localparam int CNT_W = (SETTLE_CYCLES > 4) ? $clog2(SETTLE_CYCLES) : 2;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(3);
    localparam logic [POS_W-1:0] LAST_POS    = POS_W'(NUM_POS - 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_SETTLE    = 4'd1;
    localparam logic [3:0] S_SAMPLE    = 4'd2;
    localparam logic [3:0] S_COMPARE   = 4'd3;
    localparam logic [3:0] S_NEXT      = 4'd4;
    localparam logic [3:0] S_PARK      = 4'd5;
    localparam logic [3:0] S_DISP_REQ  = 4'd6;
    localparam logic [3:0] S_DISP_WAIT = 4'd7;
    localparam logic [3:0] S_DONE      = 4'd8;

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [13:0]      sum;
    logic [POS_W-1:0] position;
    logic [11:0]      peak;
    logic [POS_W-1:0] peak_pos;
    logic [11:0]      bcd_q;
    logic [11:0]      avg;
    logic             issue;

    assign avg   = sum[13:2];
    assign issue = (state == S_DISP_REQ) && !i_BCD_Busy && !i_Abort;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sum      <= '0;
            position <= '0;
            peak     <= '0;
            peak_pos <= '0;
            bcd_q    <= '0;
        end else if (i_Abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_Start && !i_Abort) begin
                        position <= '0;
                        peak     <= '0;
                        peak_pos <= '0;
                        cnt      <= '0;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        sum   <= '0;
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    sum <= sum + 14'(i_ADC_Value);
                    if (cnt == SAMPLE_LAST) begin
                        cnt   <= '0;
                        state <= S_COMPARE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_COMPARE: begin
                    // strict compare keeps the earliest position on ties
                    if (avg > peak) begin
                        peak     <= avg;
                        peak_pos <= position;
                    end
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    cnt <= '0;
                    if (position == LAST_POS) begin
                        position <= peak_pos;
                        state    <= S_PARK;
                    end else begin
                        position <= position + POS_W'(1);
                        state    <= S_SETTLE;
                    end
                end
                S_PARK: begin
                    if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_DISP_REQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DISP_REQ: begin
                    if (!i_BCD_Busy) begin
                        bcd_q <= peak;
                        state <= S_DISP_WAIT;
                    end
                end
                S_DISP_WAIT: begin
                    if (!i_BCD_Busy) state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // data is presented in the issue cycle and held from the register after it
    assign o_BCD_Start     = issue;
    assign o_BCD_Data      = issue ? peak : bcd_q;
    assign o_Position      = position;
    assign o_Peak_Value    = peak;
    assign o_Peak_Position = peak_pos;
    assign o_Busy          = (state != S_IDLE);
    assign o_Done          = (state == S_DONE) && !i_Abort;

endmodule

// File: tb/tb_peak_sweep_scheduler.sv
// Directed bench for peak_sweep_scheduler: timing, peak search, handshake,
// abort and asynchronous reset.
module tb_peak_sweep_scheduler;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [11:0] adc;
    logic        busy;
    logic [2:0]  pos;
    logic [11:0] peak_val;
    logic [2:0]  peak_pos;
    logic        bcd_start;
    logic [11:0] bcd_data;
    logic        dut_busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    peak_sweep_scheduler #(
        .NUM_POS(8),
        .POS_W(3),
        .SETTLE_CYCLES(16)
    ) dut (
        .i_Clock(clk),
        .i_Reset_n(rst_n),
        .i_Start(start),
        .i_Abort(abort),
        .i_ADC_Value(adc),
        .i_BCD_Busy(busy),
        .o_Position(pos),
        .o_Peak_Value(peak_val),
        .o_Peak_Position(peak_pos),
        .o_BCD_Start(bcd_start),
        .o_BCD_Data(bcd_data),
        .o_Busy(dut_busy),
        .o_Done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] adc_val(input int mode, input int p,
                                            input int s);
        int t1[8] = '{10, 50, 900, 900, 3, 4095, 7, 0};
        int t3[8] = '{5, 9, 9, 3, 9, 2, 1, 9};
        case (mode)
            0: return 12'd100;
            1: return 12'(t1[p]);
            2: return (p == 2) ? 12'(s + 1) : 12'd1;
            3: return 12'(t3[p]);
            4: begin
                if (p == 7) return 12'd4095;
                if (p == 6) return (s == 3) ? 12'd4094 : 12'd4095;
                return 12'd0;
            end
            default: return 12'd0;
        endcase
    endfunction

    // Cycle n is the n-th clock after the accepting edge; inputs change
    // 1 time unit after a rising edge and outputs are read at the falling edge.
    task automatic run_sweep(input int mode, input int req_busy,
                             input int wait_busy, input int stop_at,
                             input int exp_peak, input int exp_pos);
        int limit;
        int exp_done;
        int done_cyc  = 0;
        int dones     = 0;
        int starts    = 0;
        int start_cyc = 0;
        int bcd_seen  = 0;
        int p;
        int o;
        exp_done = 195 + req_busy + wait_busy;
        limit = (stop_at != 0) ? stop_at : exp_done + 3;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= limit; n++) begin
            p = (n - 1) / 22;
            o = (n - 1) % 22;
            if (n <= 176 && o >= 16 && o <= 19)
                adc = adc_val(mode, p, o - 16);
            else
                adc = 12'hABC;
            busy = (n >= 193 && n <= 192 + req_busy) ||
                   (n >= 194 + req_busy && n <= 193 + req_busy + wait_busy);
            @(negedge clk);
            if (bcd_start) begin
                starts++;
                start_cyc = n;
                bcd_seen  = int'(bcd_data);
            end
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = n;
            end
            if (n == 1) begin
                check("first_pos", 32'(pos), 0);
                check("peak_cleared", 32'(peak_val), 0);
                check("peakpos_cleared", 32'(peak_pos), 0);
                check("busy_running", 32'(dut_busy), 1);
            end
            if (n == 23) check("pos_step", 32'(pos), 1);
            if (n == 176) check("pos_last", 32'(pos), 7);
            if (n == 177) check("park_pos_entry", 32'(pos), 32'(exp_pos));
            if (n == 192) check("park_pos_hold", 32'(pos), 32'(exp_pos));
            if (n == exp_done + 1) check("idle_after_done", 32'(dut_busy), 0);
            if (n < limit) begin
                @(posedge clk);
                #1;
            end
        end
        if (stop_at == 0) begin
            check("done_cycle", 32'(done_cyc), 32'(exp_done));
            check("done_count", 32'(dones), 1);
            check("bcd_start_count", 32'(starts), 1);
            check("bcd_start_cycle", 32'(start_cyc), 32'(193 + req_busy));
            check("bcd_data_issue", 32'(bcd_seen), 32'(exp_peak));
            check("bcd_data_held", 32'(bcd_data), 32'(exp_peak));
            check("peak_value", 32'(peak_val), 32'(exp_peak));
            check("peak_position", 32'(peak_pos), 32'(exp_pos));
            busy = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        adc   = '0;
        busy  = 1'b0;
        #23;
        check("rst_busy", 32'(dut_busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_bcd_start", 32'(bcd_start), 0);
        check("rst_pos", 32'(pos), 0);
        check("rst_peak", 32'(peak_val), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // start and abort together in IDLE must not start a sweep
        @(posedge clk);
        #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk);
        #1 begin start = 1'b0; abort = 1'b0; end
        @(negedge clk);
        check("start_abort_idle", 32'(dut_busy), 0);

        run_sweep(0, 0, 0, 0, 100, 0);
        run_sweep(1, 20, 0, 0, 4095, 5);
        run_sweep(2, 0, 3, 0, 2, 2);
        run_sweep(3, 0, 0, 0, 9, 1);
        run_sweep(4, 0, 0, 0, 4095, 7);

        // abort during position 3 settle
        run_sweep(1, 0, 0, 69, 0, 0);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        check("abort_cycle_busy", 32'(dut_busy), 1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_idle", 32'(dut_busy), 0);
        check("abort_no_done", 32'(done), 0);
        check("abort_pos_hold", 32'(pos), 3);
        check("abort_peak_hold", 32'(peak_val), 900);
        check("abort_peakpos_hold", 32'(peak_pos), 2);
        run_sweep(0, 0, 0, 0, 100, 0);

        // asynchronous reset while waiting on the converter
        run_sweep(0, 0, 5, 195, 0, 0);
        check("disp_wait_busy", 32'(dut_busy), 1);
        #2 rst_n = 1'b0;
        busy = 1'b0;
        #1;
        check("arst_busy", 32'(dut_busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_bcd_start", 32'(bcd_start), 0);
        check("arst_bcd_data", 32'(bcd_data), 0);
        check("arst_pos", 32'(pos), 0);
        check("arst_peak", 32'(peak_val), 0);
        check("arst_peakpos", 32'(peak_pos), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_sweep(0, 0, 0, 0, 100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peak_sweep_scheduler.md
PEAK_SWEEP_SCHEDULER -- requirements
Module: peak_sweep_scheduler

Interface
REQ-001 The block SHALL have the parameter NUM_POS, default 8, giving the number of sweep positions (2..256).
REQ-002 The block SHALL have the parameter POS_W, default 3, giving the position width; it satisfies 2^POS_W >= NUM_POS.
REQ-003 The block SHALL have the parameter SETTLE_CYCLES, default 16, giving the settle time per position in clocks (>= 1).
REQ-004 The block SHALL have the port i_Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have the port i_Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have the port i_Start, input, 1 bit: a level sampled in IDLE that begins a sweep.
REQ-007 The block SHALL have the port i_Abort, input, 1 bit: a synchronous abort of the current sweep.
REQ-008 The block SHALL have the port i_ADC_Value, input, 12 bits: the light-sensor ADC sample.
REQ-009 The block SHALL have the port i_BCD_Busy, input, 1 bit: the downstream binary-to-BCD converter is converting.
REQ-010 The block SHALL have the port o_Position, output, POS_W bits: the commanded panel position.
REQ-011 The block SHALL have the port o_Peak_Value, output, 12 bits: the largest averaged sample of the current or last sweep.
REQ-012 The block SHALL have the port o_Peak_Position, output, POS_W bits: the position of o_Peak_Value.
REQ-013 The block SHALL have the port o_BCD_Start, output, 1 bit: a one-cycle request to the converter.
REQ-014 The block SHALL have the port o_BCD_Data, output, 12 bits: the value to convert, valid while o_BCD_Start is high and held afterwards.
REQ-015 The block SHALL have the port o_Busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have the port o_Done, output, 1 bit: a one-cycle pulse when a sweep completes.

Function
REQ-017 The FSM states SHALL be IDLE, SETTLE, SAMPLE, COMPARE, NEXT, PARK, DISP_REQ, DISP_WAIT and DONE.
REQ-018 In IDLE with i_Start=1, the block SHALL, on the next edge, set o_Position=0, clear the peak value and peak position to 0, and enter SETTLE.
REQ-019 i_Start outside IDLE SHALL be ignored.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-021 SAMPLE SHALL last exactly 4 cycles, accumulating i_ADC_Value on each edge into a 14-bit sum that is cleared on SAMPLE entry.
REQ-022 COMPARE SHALL last 1 cycle, with avg = sum[13:2] (truncating).
REQ-023 If avg > peak (strict), COMPARE SHALL update the peak to avg and the peak position to o_Position.
REQ-024 On ties, the earliest position SHALL be retained.
REQ-025 NEXT SHALL last 1 cycle: if o_Position == NUM_POS-1, go to PARK; else increment o_Position and go to SETTLE.
REQ-026 o_Position SHALL never exceed NUM_POS-1, with no wrap.
REQ-027 PARK SHALL set o_Position = peak position on entry, then hold for exactly SETTLE_CYCLES cycles before entering DISP_REQ.
REQ-028 DISP_REQ SHALL wait while i_BCD_Busy=1; in the first cycle with i_BCD_Busy=0 it drives o_BCD_Start=1 and o_BCD_Data=peak, then enters DISP_WAIT.
REQ-029 DISP_WAIT SHALL last at least 1 cycle and exit to DONE in the first cycle with i_BCD_Busy=0 after that.
REQ-030 DONE SHALL last 1 cycle with o_Done=1, then return to IDLE.
REQ-031 o_BCD_Start SHALL be high only in the DISP_REQ issue cycle, and never for 2 consecutive cycles.
REQ-032 i_Abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no o_Done and no o_BCD_Start; o_Position and the peak registers hold.
REQ-033 i_Abort SHALL have priority over every other transition.
REQ-034 i_Abort in IDLE SHALL have no effect; if i_Start and i_Abort are both 1 in IDLE, the block SHALL stay in IDLE.
REQ-035 o_Peak_Value and o_Peak_Position SHALL hold after DONE until the next accepted i_Start.

Reset
REQ-036 Asserting i_Reset_n=0 SHALL immediately force IDLE and clear o_Position, o_Peak_Value, o_Peak_Position, o_BCD_Data, the sum and the counters to 0.
REQ-037 Asserting i_Reset_n=0 SHALL immediately deassert o_BCD_Start, o_Busy and o_Done, including mid-sweep and mid-handshake.
REQ-038 After release of reset, the first i_Start SHALL be accepted on the first edge.

Verification
REQ-039 Scenario: defaults, ADC constant 100, i_BCD_Busy=0, i_Start pulse -> o_Done high exactly 195 cycles after the accepting edge; o_Peak_Value=100; o_Peak_Position=0; one o_BCD_Start with o_BCD_Data=100.
REQ-040 Scenario: ADC per position {10,50,900,900,3,4095,7,0} -> peak=4095 at position 5; o_Position=5 from PARK on.
REQ-041 Scenario: position 2 samples {1,2,3,4} (avg 2) and all others 1 -> peak=2 at position 2, confirming truncation; tie cases keep the lower position.
REQ-042 Scenario: i_BCD_Busy held 1 for 20 cycles at DISP_REQ entry -> o_BCD_Start issued on the first cycle busy=0; o_Done is delayed by exactly 20 cycles.
REQ-043 Scenario: i_Abort at position 3 SETTLE -> IDLE next cycle, o_Busy=0, no o_Done; a new i_Start restarts at position 0 with the peak cleared.
REQ-044 Scenario: i_Reset_n pulsed low during DISP_WAIT -> all outputs 0 asynchronously; a subsequent sweep completes normally.
